// File: rtl/conv_pe_accum_ctrl.sv
// Channel-accumulating 3x3 convolution PE: 9-tap dot product per window, summed over
// input channels into a DEPTH-entry accumulator, then streamed out. Optional ReLU on readout: CONV_PE_RELU_EN.
module conv_pe_accum_ctrl #(
    parameter int PIXEL_WIDTH  = 16,
    parameter int KERNEL_WIDTH = 16,
    parameter int RESULT_WIDTH = 48,
    parameter int DEPTH        = 16384,
    parameter int MAX_CH       = 256,
    localparam int ADDR_W      = $clog2(DEPTH),
    localparam int CH_W        = $clog2(MAX_CH + 1)
) (
    input  logic                        clk,
    input  logic                        Rst,
    input  logic                        start,
    input  logic [CH_W-1:0]             num_ch,
    input  logic [RESULT_WIDTH-1:0]     bias,
    input  logic                        k_valid,
    output logic                        k_ready,
    input  logic [9*KERNEL_WIDTH-1:0]   kernel_flat,
    input  logic                        win_valid,
    output logic                        win_ready,
    input  logic [9*PIXEL_WIDTH-1:0]    win_flat,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [RESULT_WIDTH-1:0]     rd_data,
    output logic                        busy,
    output logic                        done
);

    localparam int PROD_W = PIXEL_WIDTH + KERNEL_WIDTH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_K  = 3'd1;
    localparam logic [2:0] ST_ACCUM   = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_READOUT = 3'd4;

    function automatic logic signed [RESULT_WIDTH-1:0] out_xform(input logic signed [RESULT_WIDTH-1:0] v);
`ifdef CONV_PE_RELU_EN
        return v[RESULT_WIDTH-1] ? {RESULT_WIDTH{1'b0}} : v;
`else
        return v;
`endif
    endfunction

    logic [2:0]                       state_r;
    logic [ADDR_W-1:0]                addr_r;
    logic [CH_W-1:0]                  ch_left_r;
    logic                             first_r;
    logic signed [RESULT_WIDTH-1:0]   bias_r;
    logic signed [KERNEL_WIDTH-1:0]   kern_r [9];
    logic                             drain_cnt_r;
    logic                             all_loaded_r;
    logic                             rd_valid_r;
    logic [RESULT_WIDTH-1:0]          rd_data_r;
    logic                             done_r;

    logic                             s1_valid_r;
    logic                             s1_first_r;
    logic [ADDR_W-1:0]                s1_addr_r;
    logic signed [PROD_W-1:0]         prod_r [9];
    logic signed [RESULT_WIDTH-1:0]   mem_rd_r;
    logic signed [RESULT_WIDTH-1:0]   acc_mem_r [DEPTH];

    logic                             k_hs_s;
    logic                             win_hs_s;
    logic                             rd_hs_s;
    logic                             rd_load_s;
    logic signed [RESULT_WIDTH-1:0]   sum_s;
    logic signed [RESULT_WIDTH-1:0]   wr_data_s;

    assign busy      = (state_r != ST_IDLE);
    assign k_ready   = (state_r == ST_LOAD_K);
    assign win_ready = (state_r == ST_ACCUM);
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign done      = done_r;

    assign k_hs_s    = k_valid & k_ready;
    assign win_hs_s  = win_valid & win_ready;
    assign rd_hs_s   = rd_valid_r & rd_ready;
    // Refill the output register whenever it is empty or being drained this cycle.
    assign rd_load_s = (state_r == ST_READOUT) & ~all_loaded_r & (~rd_valid_r | rd_ready);

    // Stage-2 adder tree: sign-extended products plus bias (first pass) or the stored partial sum.
    always_comb begin
        sum_s = {RESULT_WIDTH{1'b0}};
        for (int i = 0; i < 9; i++) begin
            sum_s = sum_s + RESULT_WIDTH'(prod_r[i]);
        end
        if (s1_first_r) begin
            wr_data_s = sum_s + bias_r;
        end else begin
            wr_data_s = sum_s + mem_rd_r;
        end
    end

    // Control FSM, channel/address bookkeeping, kernel capture and output register.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_r      <= ST_IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            ch_left_r    <= {CH_W{1'b0}};
            first_r      <= 1'b0;
            bias_r       <= {RESULT_WIDTH{1'b0}};
            drain_cnt_r  <= 1'b0;
            all_loaded_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_data_r    <= {RESULT_WIDTH{1'b0}};
            done_r       <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                kern_r[i] <= {KERNEL_WIDTH{1'b0}};
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ch_left_r <= (num_ch == {CH_W{1'b0}}) ? CH_W'(1) : num_ch;
                        first_r   <= 1'b1;
                        bias_r    <= bias;
                        addr_r    <= {ADDR_W{1'b0}};
                        state_r   <= ST_LOAD_K;
                    end
                end
                ST_LOAD_K: begin
                    if (k_hs_s) begin
                        for (int i = 0; i < 9; i++) begin
                            kern_r[i] <= kernel_flat[(9-i)*KERNEL_WIDTH-1 -: KERNEL_WIDTH];
                        end
                        state_r <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (win_hs_s) begin
                        if (addr_r == LAST_ADDR) begin
                            addr_r      <= {ADDR_W{1'b0}};
                            drain_cnt_r <= 1'b0;
                            state_r     <= ST_DRAIN;
                        end else begin
                            addr_r <= addr_r + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Two cycles here let the last pipelined write land before anyone reads it.
                    if (drain_cnt_r) begin
                        if (ch_left_r > CH_W'(1)) begin
                            ch_left_r <= ch_left_r - CH_W'(1);
                            first_r   <= 1'b0;
                            state_r   <= ST_LOAD_K;
                        end else begin
                            all_loaded_r <= 1'b0;
                            addr_r       <= {ADDR_W{1'b0}};
                            state_r      <= ST_READOUT;
                        end
                    end else begin
                        drain_cnt_r <= 1'b1;
                    end
                end
                ST_READOUT: begin
                    if (rd_load_s) begin
                        rd_data_r  <= out_xform(acc_mem_r[addr_r]);
                        rd_valid_r <= 1'b1;
                        if (addr_r == LAST_ADDR) begin
                            all_loaded_r <= 1'b1;
                            addr_r       <= {ADDR_W{1'b0}};
                        end else begin
                            addr_r <= addr_r + ADDR_W'(1);
                        end
                    end else if (rd_hs_s) begin
                        rd_valid_r <= 1'b0;
                        if (all_loaded_r) begin
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage 1: register the nine products and the target address on each window handshake.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            s1_valid_r <= 1'b0;
            s1_first_r <= 1'b0;
            s1_addr_r  <= {ADDR_W{1'b0}};
            for (int i = 0; i < 9; i++) begin
                prod_r[i] <= {PROD_W{1'b0}};
            end
        end else begin
            s1_valid_r <= win_hs_s;
            if (win_hs_s) begin
                s1_first_r <= first_r;
                s1_addr_r  <= addr_r;
                for (int i = 0; i < 9; i++) begin
                    prod_r[i] <= $signed(win_flat[(9-i)*PIXEL_WIDTH-1 -: PIXEL_WIDTH]) * kern_r[i];
                end
            end
        end
    end

    // Accumulator RAM: synchronous read alongside stage 1, write from stage 2; never reset.
    always_ff @(posedge clk) begin
        mem_rd_r <= acc_mem_r[addr_r];
        if (s1_valid_r) begin
            acc_mem_r[s1_addr_r] <= wr_data_s;
        end
    end

endmodule

// File: tb/tb_conv_pe_accum_ctrl.sv
// Scoreboard bench for conv_pe_accum_ctrl (DEPTH=4): directed jobs push expected results,
// an independent monitor pops and compares every readout beat.
module tb_conv_pe_accum_ctrl;

    localparam int PW = 16;
    localparam int KW = 16;
    localparam int RW = 48;
    localparam int DEPTH = 4;
    localparam int MAX_CH = 256;
    localparam int CH_W = 9;

    logic clk;
    logic rst_n;
    logic start;
    logic [CH_W-1:0] num_ch;
    logic [RW-1:0] bias;
    logic k_valid, k_ready;
    logic [9*KW-1:0] kernel_flat;
    logic win_valid, win_ready;
    logic [9*PW-1:0] win_flat;
    logic rd_valid, rd_ready;
    logic [RW-1:0] rd_data;
    logic busy, done;

    conv_pe_accum_ctrl #(
        .PIXEL_WIDTH(PW), .KERNEL_WIDTH(KW), .RESULT_WIDTH(RW),
        .DEPTH(DEPTH), .MAX_CH(MAX_CH)
    ) dut (
        .clk(clk), .Rst(rst_n), .start(start), .num_ch(num_ch), .bias(bias),
        .k_valid(k_valid), .k_ready(k_ready), .kernel_flat(kernel_flat),
        .win_valid(win_valid), .win_ready(win_ready), .win_flat(win_flat),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [RW-1:0] exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    bit gap_rd = 1'b0;

    task automatic check(input string name, input longint act, input longint expv);
        vec_cnt++;
        if (act != expv) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic finish_bench();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    endtask

    function automatic logic [9*PW-1:0] pack9(input int v[9]);
        logic [9*PW-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[(9-i)*PW-1 -: PW] = v[i][PW-1:0];
        return r;
    endfunction

    // mode 0: every tap = wval; mode 1: centre tap = addr + wval, others 0
    function automatic logic [9*PW-1:0] build_win(input int mode, input int wval, input int a);
        int v[9];
        for (int i = 0; i < 9; i++) v[i] = (mode == 0) ? wval : 0;
        if (mode == 1) v[4] = a + wval;
        return pack9(v);
    endfunction

    // Monitor: pops the scoreboard on each read handshake and checks stall stability.
    initial begin
        logic signed [RW-1:0] held_data;
        logic signed [RW-1:0] e;
        bit held;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) done_cnt++;
                if (held && rd_valid) check("stall_stable", $signed(rd_data), held_data);
                held = rd_valid && !rd_ready;
                held_data = rd_data;
                if (rd_valid && rd_ready) begin
                    if (exp_q.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_beat: got %0d, expected no output", $signed(rd_data));
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", $signed(rd_data), e);
                    end
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Consumer: rd_ready always high, or 50% random when gaps are enabled.
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = gap_rd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic wait_ready(input int which, input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if ((which == 0 && k_ready) || (which == 1 && win_ready)) break;
            n++;
            if (n > 200) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL %s_timeout: got no ready, expected ready within 200 cycles", name);
                finish_bench();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_k_ready"}, k_ready, 0);
        check({tag, "_win_ready"}, win_ready, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_data"}, rd_data, 0);
    endtask

    task automatic run_job(input int nch, input longint b, input int k[9], input int wmode,
                           input int wval, input bit gaps, input bit hold_start,
                           input int abort_ch, input longint e[DEPTH]);
        int base_done;
        int passes;
        int n;
        if (abort_ch < 0) for (int i = 0; i < DEPTH; i++) exp_q.push_back(RW'(e[i]));
        base_done = done_cnt;
        gap_rd = gaps;
        passes = (nch == 0) ? 1 : nch;
        num_ch = CH_W'(nch);
        bias = b[RW-1:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        for (int ch = 0; ch < passes; ch++) begin
            kernel_flat = pack9(k);
            k_valid = 1'b1;
            wait_ready(0, "k_ready");
            k_valid = 1'b0;
            if (hold_start) num_ch = CH_W'(3);
            for (int a = 0; a < DEPTH; a++) begin
                if (ch == abort_ch && a == 2) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check_reset_outputs("abort");
                    exp_q.delete();
                    win_valid = 1'b0;
                    start = 1'b0;
                    @(posedge clk);
                    #1;
                    check_reset_outputs("abort_hold");
                    rst_n = 1'b1;
                    @(posedge clk);
                    #1;
                    gap_rd = 1'b0;
                    return;
                end
                if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                win_flat = build_win(wmode, wval, a);
                win_valid = 1'b1;
                wait_ready(1, "win_ready");
                win_valid = 1'b0;
            end
        end
        start = 1'b0;
        n = 0;
        while (done_cnt == base_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - base_done, 1);
        check("results_left", exp_q.size(), 0);
        check("idle_busy", busy, 0);
        check("idle_rd_valid", rd_valid, 0);
        gap_rd = 1'b0;
    endtask

    initial begin
        int k[9];
        longint e[DEPTH];
        rst_n = 1'b0;
        start = 1'b0;
        num_ch = '0;
        bias = '0;
        k_valid = 1'b0;
        kernel_flat = '0;
        win_valid = 1'b0;
        win_flat = '0;
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_k_ready", k_ready, 0);
        check("idle_win_ready", win_ready, 0);

        // bias 5, kernel all 1, windows all 2: 9*2+5
        for (int i = 0; i < 9; i++) k[i] = 1;
        e = '{23, 23, 23, 23};
        run_job(1, 5, k, 0, 2, 1'b0, 1'b0, -1, e);

        // three channels, centre-only kernel, centre = addr+1, bias -10
        for (int i = 0; i < 9; i++) k[i] = 0;
        k[4] = 1;
`ifdef CONV_PE_RELU_EN
        e = '{0, 0, 0, 2};
`else
        e = '{-7, -4, -1, 2};
`endif
        run_job(3, -10, k, 1, 1, 1'b0, 1'b0, -1, e);
        // same job with random window and readout gaps
        run_job(3, -10, k, 1, 1, 1'b1, 1'b0, -1, e);

        // kernel all -1, windows all 4: -36 (clamped to 0 with ReLU)
        for (int i = 0; i < 9; i++) k[i] = -1;
`ifdef CONV_PE_RELU_EN
        e = '{0, 0, 0, 0};
`else
        e = '{-36, -36, -36, -36};
`endif
        run_job(1, 0, k, 0, 4, 1'b0, 1'b0, -1, e);

        // abort mid-ACCUM of channel 2, then a clean single-pass job: 2*addr+7
        for (int i = 0; i < 9; i++) k[i] = 0;
        k[4] = 1;
        run_job(3, 100, k, 1, 1, 1'b0, 1'b0, 1, e);
        k[4] = 2;
        e = '{7, 9, 11, 13};
        run_job(1, 7, k, 1, 0, 1'b0, 1'b0, -1, e);

        // num_ch=0 treated as one pass while start stays high and num_ch changes mid-job
        for (int i = 0; i < 9; i++) k[i] = 1;
        e = '{10, 10, 10, 10};
        run_job(0, 1, k, 0, 1, 1'b0, 1'b1, -1, e);

        finish_bench();
    end

endmodule
